// File: rtl/crc_pkg.sv
// Shared constants and the single-bit CRC-32 update used by the parallel ECRC engine.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_ECRC_SEED = 32'hFFFF_FFFF;
  localparam int          DW_WIDTH        = 32;
  localparam int          DATA_WIDTH_DEF  = 256;
  localparam int          MAX_DWS         = DATA_WIDTH_DEF / DW_WIDTH;

  // One MSB-first, non-reflected shift of the CRC register with message bit b.
  function automatic logic [31:0] crc32_bit_step(input logic [31:0] crc, input logic b);
    logic fb;
    fb = crc[31] ^ b;
    return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/crc32_parallel_dw_step.sv
// Combinational next-CRC for one 32-bit DW, bits consumed from 31 down to 0.
module crc32_dw_step
  import crc_pkg::*;
(
  input  logic [31:0]         crc_in,
  input  logic [DW_WIDTH-1:0] data,
  output logic [31:0]         crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = DW_WIDTH - 1; i >= 0; i--) begin
      crc_out = crc32_bit_step(crc_out, data[i]);
    end
  end

endmodule

// File: rtl/crc32_parallel.sv
// Single-cycle 256-bit CRC-32 engine: folds up to eight right-aligned DWs into a running CRC.
module crc32_parallel
  import crc_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int LENGTH_WIDTH = 4,
  parameter int POLY_WIDTH   = 32
) (
  input  logic                    CRC_i_CLK,
  input  logic                    CRC_i_RST_n,
  input  logic [DATA_WIDTH-1:0]   CRC_i_Message,
  input  logic [LENGTH_WIDTH-1:0] CRC_i_Length,
  input  logic                    CRC_i_EN,
  input  logic [POLY_WIDTH-1:0]   CRC_i_Seed,
  input  logic                    CRC_i_Seed_Load,
  output logic [POLY_WIDTH-1:0]   CRC_o_CRC
);

  localparam int NDW = DATA_WIDTH / DW_WIDTH;

  logic [POLY_WIDTH-1:0]   crc_reg;
  logic [POLY_WIDTH-1:0]   crc_next;
  logic [LENGTH_WIDTH-1:0] len_eff;
  logic [DW_WIDTH-1:0]     msg_dw   [NDW];
  logic [DW_WIDTH-1:0]     stage_dw [NDW];
  logic [POLY_WIDTH-1:0]   chain    [NDW+1];

  always_comb begin
    len_eff = CRC_i_Length;
    if (CRC_i_Length > LENGTH_WIDTH'(NDW)) len_eff = LENGTH_WIDTH'(NDW);
  end

  for (genvar j = 0; j < NDW; j++) begin : g_split
    assign msg_dw[j] = CRC_i_Message[j*DW_WIDTH +: DW_WIDTH];
  end

  // Stage k must consume DW (L-1-k) so the highest valid DW always enters the chain first.
  always_comb begin
    for (int k = 0; k < NDW; k++) begin
      stage_dw[k] = '0;
      for (int j = 0; j < NDW; j++) begin
        if (int'(len_eff) == j + k + 1) stage_dw[k] = msg_dw[j];
      end
    end
  end

  assign chain[0] = CRC_i_Seed_Load ? CRC_i_Seed : crc_reg;

  for (genvar k = 0; k < NDW; k++) begin : g_chain
    crc32_dw_step u_step (
      .crc_in  (chain[k]),
      .data    (stage_dw[k]),
      .crc_out (chain[k+1])
    );
  end

  // Tap the chain after stage L; L = 0 passes the start value straight through.
  always_comb begin
    crc_next = chain[0];
    for (int k = 1; k <= NDW; k++) begin
      if (int'(len_eff) == k) crc_next = chain[k];
    end
  end

  always_ff @(posedge CRC_i_CLK) begin
    if (!CRC_i_RST_n) begin
      crc_reg <= CRC32_ECRC_SEED;
    end else if (CRC_i_EN) begin
      crc_reg <= crc_next;
    end
  end

  assign CRC_o_CRC = crc_reg;

endmodule

// File: tb/tb_crc32_parallel.sv
// Scoreboard bench for crc32_parallel: directed hand-computed vectors plus a bit-serial reference.
module tb_crc32_parallel;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] msg;
  logic [3:0]   len;
  logic         en;
  logic [31:0]  seed;
  logic         seed_load;
  logic [31:0]  crc_out;

  logic         chk;
  logic [31:0]  exp_q [$];
  string        name_q [$];
  logic [31:0]  model_crc;
  int           total;
  int           passed;

  crc32_parallel dut (
    .CRC_i_CLK       (clk),
    .CRC_i_RST_n     (rst_n),
    .CRC_i_Message   (msg),
    .CRC_i_Length    (len),
    .CRC_i_EN        (en),
    .CRC_i_Seed      (seed),
    .CRC_i_Seed_Load (seed_load),
    .CRC_o_CRC       (crc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] serial_crc(input logic [31:0] s, input logic [255:0] m,
                                             input int l_in);
    logic [31:0] c;
    logic        fb;
    int          l;
    l = (l_in > 8) ? 8 : l_in;
    c = s;
    for (int i = 32 * l - 1; i >= 0; i--) begin
      fb = c[31] ^ m[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [255:0] rand_msg();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Drive one beat at the falling edge; the bench model advances alongside.
  task automatic beat(input string nm, input logic r_n, input logic e, input logic sl,
                      input logic [31:0] sd, input logic [3:0] l, input logic [255:0] m,
                      input logic use_hand, input logic [31:0] hand);
    logic [31:0] s;
    @(negedge clk);
    rst_n = r_n; en = e; seed_load = sl; seed = sd; len = l; msg = m;
    if (!r_n) model_crc = 32'hFFFF_FFFF;
    else if (e) begin
      s = sl ? sd : model_crc;
      model_crc = serial_crc(s, m, int'(l));
    end
    exp_q.push_back(use_hand ? hand : model_crc);
    name_q.push_back(nm);
    chk = 1'b1;
  endtask

  // Monitor: after each rising edge that followed a driven beat, compare against the queue.
  always @(posedge clk) begin
    logic        do_chk;
    logic [31:0] exp_v;
    string       nm;
    do_chk = chk;
    #1;
    if (do_chk) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: got %h, required an expected entry", crc_out);
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (crc_out === exp_v) passed++;
        else $display("FAIL %s: got %h, required %h", nm, crc_out, exp_v);
      end
    end
  end

  initial begin
    logic [255:0] m;
    logic [31:0]  held;
    total = 0; passed = 0; chk = 1'b0; model_crc = 32'hFFFF_FFFF;
    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed = '0; len = '0; msg = '0;

    beat("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, '0, 1'b1, 32'hFFFF_FFFF);
    beat("seed0_msg1", 1'b1, 1'b1, 1'b1, 32'h0, 4'd1, 256'h1, 1'b1, 32'h04C11DB7);
    beat("ones_seed_ones", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'd1, 256'hFFFF_FFFF, 1'b1, 32'h0);
    beat("continuation", 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'd1, 256'h1, 1'b1, 32'h04C11DB7);
    beat("len8_msg1", 1'b1, 1'b1, 1'b1, 32'h0, 4'd8, 256'h1, 1'b1, 32'h04C11DB7);
    m = rand_msg();
    m[31:0] = 32'h1;
    beat("ignore_upper", 1'b1, 1'b1, 1'b1, 32'h0, 4'd1, m, 1'b1, 32'h04C11DB7);
    beat("len15_as_8", 1'b1, 1'b1, 1'b1, 32'h0, 4'd15, 256'h1, 1'b1, 32'h04C11DB7);
    beat("mid_reset", 1'b0, 1'b1, 1'b1, 32'h0, 4'd1, 256'h1, 1'b1, 32'hFFFF_FFFF);
    held = model_crc;
    for (int i = 0; i < 5; i++)
      beat("en_low_hold", 1'b1, 1'b0, 1'($urandom), $urandom, 4'($urandom), rand_msg(), 1'b1, held);
    beat("seed_load_len0", 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'd0, rand_msg(), 1'b1, 32'h1234_5678);
    beat("len0_continue", 1'b1, 1'b1, 1'b0, 32'h0, 4'd0, rand_msg(), 1'b1, 32'h1234_5678);

    for (int i = 0; i < 100; i++)
      beat("rand_ecrc_len8", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'd8, rand_msg(), 1'b0, 32'h0);
    for (int i = 0; i < 100; i++)
      beat("rand_chain", 1'b1, 1'b1, 1'($urandom), $urandom, 4'($urandom_range(1, 8)),
           rand_msg(), 1'b0, 32'h0);
    for (int i = 0; i < 30; i++)
      beat("rand_mixed", 1'b1, 1'($urandom), 1'($urandom), $urandom, 4'($urandom),
           rand_msg(), 1'b0, 32'h0);

    @(negedge clk);
    chk = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crc32_parallel.md
# crc32_parallel

Single-cycle, 256-bit-wide CRC-32 engine for the ECRC path of the TL transmit data-fragmentation stage. Each enabled clock it folds up to eight 32-bit DWs of TLP data into a running CRC register, starting either from a supplied seed or from the previous result. A bit-serial implementation with the same interface serves as the golden model. Both must produce identical results for every input.

## Interface
- DATA_WIDTH, 256: message bus width in bits; must be a multiple of 32.
- LENGTH_WIDTH, 4: width of the DW-count input.
- POLY_WIDTH, 32: CRC width in bits.
- CRC_i_CLK  in  1  clock.
- CRC_i_RST_n  in  1  reset. One clock; reset is synchronous and active-low.
- CRC_i_Message  in  DATA_WIDTH  message data; valid DWs are right-aligned.
- CRC_i_Length  in  LENGTH_WIDTH  number of valid DWs, 0..8.
- CRC_i_EN  in  1  update enable.
- CRC_i_Seed  in  POLY_WIDTH  starting CRC value. ECRC uses 32'hFFFF_FFFF.
- CRC_i_Seed_Load  in  1  1 = start from CRC_i_Seed; 0 = continue from the CRC register.
- CRC_o_CRC  out  POLY_WIDTH  CRC register. This is the raw remainder: no final inversion, no bit reversal.

## Operation
- Polynomial 32'h04C11DB7, non-reflected, processed MSB-first.
- Start value: S = CRC_i_Seed_Load ? CRC_i_Seed : crc_reg.
- Valid bits are CRC_i_Message[32·L-1:0], where L = CRC_i_Length.
  - They are processed from bit 32·L-1 down to bit 0.
  - Bits above 32·L are ignored.
- Per-bit step, for each message bit b:
  - fb = crc[31] ^ b.
  - crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 0).
- L = 0: no data is processed, and the result is S. A seed load with L = 0 therefore just loads the seed.
- L > 8: treated as 8.
- The parallel form is a combinational chain of 8 DW-step stages (32 bits each) tapped after stage L and muxed by L. It must equal the serial bit loop bit-for-bit for every S, message and L.
- Final complement and byte/bit mapping into the TLP digest are done downstream, not in this block.

## Timing
- On reset (CRC_i_RST_n = 0 at a rising edge), crc_reg = 32'hFFFF_FFFF.
- Reset has priority over CRC_i_EN.
- CRC_i_EN = 1 at a rising edge: crc_reg is loaded with the computed CRC of (S, message, L).
- CRC_i_EN = 0: crc_reg holds; all other inputs are don't-care.
- Latency is 1 cycle: CRC_o_CRC reflects the data presented at the previous enabled edge.
- Back-to-back enables are supported every cycle with no bubbles. Chaining uses CRC_i_Seed_Load = 0 on the continuation beats.
- Seed_Load on any beat discards the prior running value, so a new TLP can start mid-stream.
- Reset mid-TLP abandons the running CRC; the next beat must assert Seed_Load.

## Structure
- Shared package (crc_pkg) holds:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_ECRC_SEED = 32'hFFFF_FFFF
  - DW_WIDTH = 32
  - MAX_DWS = DATA_WIDTH/32
- Sub-module crc32_dw_step: combinational next-CRC for one 32-bit DW given the current CRC. It is instantiated 8 times in a chain.
- The serial model is a bench-only behavioural loop with the same ports, used as the reference.

## Test plan
- Seed 0, Seed_Load = 1, L = 1, message 32'h1 → CRC_o_CRC = 32'h04C11DB7 after one enabled edge.
- Seed FFFF_FFFF, Seed_Load = 1, L = 1, message 32'hFFFF_FFFF → 32'h0000_0000. Next beat Seed_Load = 0, L = 1, message 32'h1 → 32'h04C11DB7, proving continuation.
- Seed 0, L = 8, message 256'h1 → 32'h04C11DB7. Same message with garbage above bit 31 and L = 1 → 32'h04C11DB7, proving that bits above 32·L are ignored.
- Reset (CRC_i_RST_n = 0 for one edge) → FFFF_FFFF. EN = 0 with random inputs for 5 cycles → output unchanged. Seed_Load = 1, L = 0, seed 12345678 → 12345678.
- 100 random messages with seed FFFF_FFFF, L = 8 and Seed_Load = 1, plus random L 1..8 and random Seed_Load: the parallel result must equal the serial model on every beat, with 0 failures.
